// File: rtl/ps2_matrix_pkg.sv
// Shared constants, types and the Specialist keymap for the PS/2 matrix path.
package ps2_matrix_pkg;

  localparam logic [7:0] CODE_E0 = 8'hE0;
  localparam logic [7:0] CODE_F0 = 8'hF0;
  localparam logic [7:0] CODE_E1 = 8'hE1;
  localparam logic [7:0] CODE_AA = 8'hAA;
  localparam logic [7:0] CODE_00 = 8'h00;
  localparam logic [7:0] CODE_FF = 8'hFF;

  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_ALT    = 8'h11;
  localparam logic [7:0] CODE_CTRL   = 8'h14;
  localparam logic [7:0] CODE_DEL    = 8'h71;

  localparam int KM_ROW_W = 4;
  localparam int KM_COL_W = 3;

  localparam logic [1:0] FORCE_PASS = 2'b00;
  localparam logic [1:0] FORCE_OFF  = 2'b01;
  localparam logic [1:0] FORCE_ON   = 2'b10;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_EXT    = 3'd1;
  localparam state_t ST_BRK    = 3'd2;
  localparam state_t ST_EXTBRK = 3'd3;
  localparam state_t ST_PAUSE  = 3'd4;
  localparam state_t ST_LOOKUP = 3'd5;
  localparam state_t ST_UPDATE = 3'd6;

  typedef struct packed {
    logic                hit;
    logic [KM_ROW_W-1:0] row;
    logic [KM_COL_W-1:0] col;
    logic [1:0]          fmode;
  } keymap_t;

  function automatic keymap_t km_cell(input logic [KM_ROW_W-1:0] r,
                                      input logic [KM_COL_W-1:0] c,
                                      input logic [1:0] f);
    keymap_t e;
    e = '{hit: 1'b1, row: r, col: c, fmode: f};
    return e;
  endfunction

  // Letters move to the Cyrillic block when rus is set; some punctuation
  // lands on a different cell and forces НР depending on the PC shift state.
  function automatic keymap_t keymap_lookup(input logic rus, input logic shift,
                                            input logic ext, input logic [7:0] code);
    keymap_t e;
    e = '0;
    if (ext) begin
      case (code)
        8'h75:   e = km_cell(4'd9,  3'd0, FORCE_PASS);
        8'h72:   e = km_cell(4'd10, 3'd0, FORCE_PASS);
        8'h6B:   e = km_cell(4'd11, 3'd0, FORCE_PASS);
        8'h74:   e = km_cell(4'd11, 3'd1, FORCE_PASS);
        8'h5A:   e = km_cell(4'd5,  3'd4, FORCE_PASS);
        default: e = '0;
      endcase
    end else begin
      case (code)
        8'h76:   e = km_cell(4'd0, 3'd0, FORCE_PASS);
        8'h16:   e = km_cell(4'd0, 3'd1, FORCE_PASS);
        8'h1E:   e = km_cell(4'd0, 3'd2, FORCE_PASS);
        8'h26:   e = km_cell(4'd0, 3'd3, FORCE_PASS);
        8'h25:   e = km_cell(4'd0, 3'd4, FORCE_PASS);
        8'h2E:   e = km_cell(4'd0, 3'd5, FORCE_PASS);
        8'h36:   e = km_cell(4'd1, 3'd0, FORCE_PASS);
        8'h29:   e = km_cell(4'd5, 3'd0, FORCE_PASS);
        8'h5A:   e = km_cell(4'd5, 3'd5, FORCE_PASS);
        8'h66:   e = km_cell(4'd4, 3'd5, FORCE_PASS);
        8'h52:   e = shift ? km_cell(4'd0, 3'd2, FORCE_ON)  : km_cell(4'd1, 3'd4, FORCE_ON);
        8'h55:   e = shift ? km_cell(4'd1, 3'd3, FORCE_OFF) : km_cell(4'd1, 3'd5, FORCE_ON);
        8'h1C:   e = rus ? km_cell(4'd11, 3'd2, FORCE_PASS) : km_cell(4'd8, 3'd2, FORCE_PASS);
        8'h32:   e = rus ? km_cell(4'd11, 3'd3, FORCE_PASS) : km_cell(4'd8, 3'd3, FORCE_PASS);
        8'h21:   e = rus ? km_cell(4'd10, 3'd1, FORCE_PASS) : km_cell(4'd7, 3'd1, FORCE_PASS);
        8'h23:   e = rus ? km_cell(4'd11, 3'd4, FORCE_PASS) : km_cell(4'd8, 3'd4, FORCE_PASS);
        8'h24:   e = rus ? km_cell(4'd10, 3'd3, FORCE_PASS) : km_cell(4'd7, 3'd3, FORCE_PASS);
        8'h2B:   e = rus ? km_cell(4'd11, 3'd5, FORCE_PASS) : km_cell(4'd8, 3'd5, FORCE_PASS);
        default: e = '0;
      endcase
    end
    return e;
  endfunction

endpackage

// File: rtl/ps2_keymap.sv
// Registered keymap lookup, one cycle from enable to result.
module ps2_keymap
  import ps2_matrix_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       rus,
  input  logic       shift,
  input  logic       ext,
  input  logic [7:0] code,
  output keymap_t    entry
);

  // Capture the lookup result for the byte being accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      entry <= '0;
    end else if (en) begin
      entry <= keymap_lookup(rus, shift, ext, code);
    end
  end

endmodule

// File: rtl/ps2_matrix_mapper.sv
// PS/2 scancode to Specialist keyboard matrix mapper with a held-key table.
//
// state  | meaning
// IDLE   | waiting for a new sequence
// EXT    | E0 seen
// BRK    | F0 seen
// EXTBRK | E0 F0 seen
// PAUSE  | swallowing the rest of an E1 sequence
// LOOKUP | keymap result valid; table written on exit
// UPDATE | table holds the new state; matrix registered on exit
module ps2_matrix_mapper
  import ps2_matrix_pkg::*;
#(
  parameter int ROWS       = 12,
  parameter int COLS       = 6,
  parameter int HOLD_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 code_valid,
  input  logic [7:0]           code_data,
  output logic                 code_ready,
  output logic [ROWS*COLS-1:0] matrix_n,
  output logic                 shift_out,
  output logic                 reset_req,
  output logic                 rus,
  output logic                 overflow
);

  localparam int CELLS = ROWS * COLS;
  localparam int IDX_W = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;

  typedef struct packed {
    logic                valid;
    logic                ext;
    logic [7:0]          code;
    logic [KM_ROW_W-1:0] row;
    logic [KM_COL_W-1:0] col;
    logic [1:0]          fmode;
  } hold_t;

  state_t     state;
  logic [2:0] pause_cnt;
  logic       cur_ext, cur_brk, cur_skip;
  logic [7:0] cur_code;
  logic       shift_l, shift_r, alt_l, alt_r, ctrl_l, ctrl_r, del_held;
  logic       force_on_q, force_off_q;
  hold_t      table_q [HOLD_DEPTH];
  keymap_t    km_q;

  logic accept, in_ext, in_brk, resync_byte, final_byte;
  logic is_shift, is_fake, is_alt, is_ctrl, is_del;
  logic shift_flag, alt_flag, ctrl_flag;
  logic [HOLD_DEPTH-1:0] match;
  logic match_any, free_any, any_on, any_off;
  logic [IDX_W-1:0] free_idx;
  logic [CELLS-1:0] cell_set;

  assign code_ready  = (state != ST_LOOKUP) && (state != ST_UPDATE);
  assign accept      = code_valid && code_ready;
  assign in_ext      = (state == ST_EXT) || (state == ST_EXTBRK);
  assign in_brk      = (state == ST_BRK) || (state == ST_EXTBRK);
  assign resync_byte = accept && (state == ST_IDLE) &&
                       (code_data inside {CODE_AA, CODE_00, CODE_FF});

  assign is_shift = !in_ext && (code_data inside {CODE_LSHIFT, CODE_RSHIFT});
  assign is_fake  =  in_ext && (code_data inside {CODE_LSHIFT, CODE_RSHIFT});
  assign is_alt   = (code_data == CODE_ALT);
  assign is_ctrl  = (code_data == CODE_CTRL);
  assign is_del   = in_ext && (code_data == CODE_DEL);

  assign shift_flag = shift_l | shift_r;
  assign alt_flag   = alt_l | alt_r;
  assign ctrl_flag  = ctrl_l | ctrl_r;

  assign reset_req = ctrl_flag & alt_flag & del_held;
  assign shift_out = force_on_q | (!force_off_q & shift_flag);

  // A final byte is the one that completes a make or break sequence.
  always_comb begin
    final_byte = 1'b0;
    if (accept) begin
      case (state)
        ST_IDLE:           final_byte = !(code_data inside {CODE_E0, CODE_F0, CODE_E1}) && !resync_byte;
        ST_EXT:            final_byte = (code_data != CODE_F0);
        ST_BRK, ST_EXTBRK: final_byte = 1'b1;
        default:           final_byte = 1'b0;
      endcase
    end
  end

  ps2_keymap u_keymap (
    .clk   (clk),
    .reset (reset),
    .en    (final_byte),
    .rus   (rus),
    .shift (shift_flag),
    .ext   (in_ext),
    .code  (code_data),
    .entry (km_q)
  );

  // Prefix FSM, pause byte counter and capture of the completed sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      pause_cnt <= '0;
      cur_ext   <= 1'b0;
      cur_brk   <= 1'b0;
      cur_skip  <= 1'b0;
      cur_code  <= '0;
    end else begin
      if (final_byte) begin
        cur_ext  <= in_ext;
        cur_brk  <= in_brk;
        cur_skip <= is_shift | is_fake | is_alt | is_ctrl;
        cur_code <= code_data;
      end
      case (state)
        ST_IDLE: if (accept) begin
          if (code_data == CODE_E0)      state <= ST_EXT;
          else if (code_data == CODE_F0) state <= ST_BRK;
          else if (code_data == CODE_E1) begin
            state     <= ST_PAUSE;
            pause_cnt <= 3'd6;
          end else if (!resync_byte)     state <= ST_LOOKUP;
        end
        ST_EXT:            if (accept) state <= (code_data == CODE_F0) ? ST_EXTBRK : ST_LOOKUP;
        ST_BRK, ST_EXTBRK: if (accept) state <= ST_LOOKUP;
        ST_PAUSE: if (accept) begin
          if (pause_cnt == 3'd0) state <= ST_IDLE;
          else                   pause_cnt <= pause_cnt - 3'd1;
        end
        ST_LOOKUP: state <= ST_UPDATE;
        ST_UPDATE: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Modifier flags and layout toggle follow the byte directly, not the table.
  always_ff @(posedge clk) begin
    if (reset) begin
      {shift_l, shift_r, alt_l, alt_r, ctrl_l, ctrl_r, del_held} <= '0;
      rus <= 1'b0;
    end else if (resync_byte) begin
      {shift_l, shift_r, alt_l, alt_r, ctrl_l, ctrl_r, del_held} <= '0;
    end else if (final_byte) begin
      if (is_shift) begin
        if (code_data == CODE_LSHIFT) shift_l <= !in_brk;
        else                          shift_r <= !in_brk;
        if (in_brk && alt_flag) rus <= !rus;
      end
      if (is_alt) begin
        if (in_ext) alt_r <= !in_brk;
        else        alt_l <= !in_brk;
        if (in_brk && shift_flag) rus <= !rus;
      end
      if (is_ctrl) begin
        if (in_ext) ctrl_r <= !in_brk;
        else        ctrl_l <= !in_brk;
      end
      if (is_del) del_held <= !in_brk;
    end
  end

  // Find the entry matching the captured key and the lowest free slot.
  always_comb begin
    match     = '0;
    match_any = 1'b0;
    free_any  = 1'b0;
    free_idx  = '0;
    for (int i = HOLD_DEPTH - 1; i >= 0; i--) begin
      if (table_q[i].valid && (table_q[i].ext == cur_ext) && (table_q[i].code == cur_code)) begin
        match[i]  = 1'b1;
        match_any = 1'b1;
      end
      if (!table_q[i].valid) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  // Hold table: the cell a key set is remembered so its release clears that same cell.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < HOLD_DEPTH; i++) table_q[i] <= '0;
      overflow <= 1'b0;
    end else if (resync_byte) begin
      for (int i = 0; i < HOLD_DEPTH; i++) table_q[i].valid <= 1'b0;
      overflow <= 1'b0;
    end else if ((state == ST_LOOKUP) && !cur_skip) begin
      if (cur_brk) begin
        for (int i = 0; i < HOLD_DEPTH; i++) begin
          if (match[i]) table_q[i].valid <= 1'b0;
        end
      end else if (km_q.hit && !match_any) begin
        if (!free_any) overflow <= 1'b1;
        else table_q[free_idx] <= '{valid: 1'b1, ext: cur_ext, code: cur_code,
                                    row: km_q.row, col: km_q.col, fmode: km_q.fmode};
      end
    end
  end

  // OR-reduce held entries onto matrix cells and collect shift overrides.
  always_comb begin
    cell_set = '0;
    any_on   = 1'b0;
    any_off  = 1'b0;
    for (int i = 0; i < HOLD_DEPTH; i++) begin
      if (table_q[i].valid && (table_q[i].fmode == FORCE_ON))  any_on  = 1'b1;
      if (table_q[i].valid && (table_q[i].fmode == FORCE_OFF)) any_off = 1'b1;
    end
    for (int c = 0; c < CELLS; c++) begin
      for (int i = 0; i < HOLD_DEPTH; i++) begin
        if (table_q[i].valid && (int'(table_q[i].row) == c / COLS) &&
            (int'(table_q[i].col) == c % COLS)) cell_set[c] = 1'b1;
      end
    end
  end

  // Register the matrix and shift overrides one cycle after the table changes.
  always_ff @(posedge clk) begin
    if (reset) begin
      matrix_n    <= '1;
      force_on_q  <= 1'b0;
      force_off_q <= 1'b0;
    end else begin
      matrix_n    <= ~cell_set;
      force_on_q  <= any_on;
      force_off_q <= any_off;
    end
  end

endmodule

// File: tb/tb_ps2_matrix_mapper.sv
// Directed bench for ps2_matrix_mapper with hand-computed matrix expectations.
module tb_ps2_matrix_mapper;

  localparam int CELLS = 72;
  localparam logic [CELLS-1:0] ALL1 = {CELLS{1'b1}};

  logic clk = 1'b0;
  logic reset, code_valid, code_ready, shift_out, reset_req, rus, overflow;
  logic [7:0] code_data;
  logic [CELLS-1:0] matrix_n;
  logic [CELLS-1:0] e;
  int checks = 0;
  int failures = 0;

  ps2_matrix_mapper #(.ROWS(12), .COLS(6), .HOLD_DEPTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .code_valid (code_valid),
    .code_data  (code_data),
    .code_ready (code_ready),
    .matrix_n   (matrix_n),
    .shift_out  (shift_out),
    .reset_req  (reset_req),
    .rus        (rus),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_vec(input string tag, input logic [CELLS-1:0] obs, input logic [CELLS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (code_ready !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk_bit("ready_bound", code_ready, 1'b1);
  endtask

  task automatic send(input logic [7:0] b);
    wait_ready();
    code_data  = b;
    code_valid = 1'b1;
    @(posedge clk);
    #1;
    code_valid = 1'b0;
  endtask

  task automatic key(input logic [7:0] b);
    send(b);
    wait_ready();
  endtask

  initial begin
    reset = 1'b1;
    code_valid = 1'b0;
    code_data = 8'h00;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk_vec("rst_matrix", matrix_n, ALL1);
    chk_bit("rst_shift", shift_out, 1'b0);
    chk_bit("rst_reset_req", reset_req, 1'b0);
    chk_bit("rst_rus", rus, 1'b0);
    chk_bit("rst_overflow", overflow, 1'b0);
    chk_bit("rst_ready", code_ready, 1'b1);

    // make 1C with latency check, then release
    send(8'h1C);
    tick(1);
    chk_vec("t1_before", matrix_n, ALL1);
    chk_bit("t1_busy", code_ready, 1'b0);
    tick(1);
    e = ALL1; e[50] = 1'b0;
    chk_vec("t1_make", matrix_n, e);
    chk_bit("t1_ready", code_ready, 1'b1);
    send(8'hF0); key(8'h1C);
    chk_vec("t1_break", matrix_n, ALL1);

    // layout toggle while 1C held
    key(8'h1C);
    key(8'h12);
    chk_bit("t2_shift_on", shift_out, 1'b1);
    key(8'h11);
    send(8'hF0); key(8'h11);
    chk_bit("t2_rus", rus, 1'b1);
    send(8'hF0); key(8'h12);
    chk_bit("t2_rus_kept", rus, 1'b1);
    chk_bit("t2_shift_off", shift_out, 1'b0);
    e = ALL1; e[50] = 1'b0;
    chk_vec("t2_held", matrix_n, e);
    send(8'hF0); key(8'h1C);
    chk_vec("t2_release", matrix_n, ALL1);
    key(8'h1C);
    e = ALL1; e[68] = 1'b0;
    chk_vec("t2_rus_make", matrix_n, e);
    send(8'hF0); key(8'h1C);
    chk_vec("t2_rus_break", matrix_n, ALL1);

    // typematic repeats
    key(8'h29);
    e = ALL1; e[30] = 1'b0;
    chk_vec("t3_first", matrix_n, e);
    repeat (4) key(8'h29);
    chk_vec("t3_repeat", matrix_n, e);
    send(8'hF0); key(8'h29);
    chk_vec("t3_break", matrix_n, ALL1);

    // fill the table, overflow, resync
    key(8'h76); key(8'h16); key(8'h1E); key(8'h26);
    key(8'h25); key(8'h2E); key(8'h36); key(8'h29);
    e = ALL1; e[6:0] = '0; e[30] = 1'b0;
    chk_vec("t4_full", matrix_n, e);
    chk_bit("t4_no_ovf", overflow, 1'b0);
    key(8'h5A);
    chk_vec("t4_dropped", matrix_n, e);
    chk_bit("t4_ovf", overflow, 1'b1);
    send(8'hAA);
    tick(1);
    chk_vec("t4_resync", matrix_n, ALL1);
    chk_bit("t4_ovf_clr", overflow, 1'b0);
    chk_bit("t4_rus_kept", rus, 1'b1);
    key(8'h5A);
    e = ALL1; e[35] = 1'b0;
    chk_vec("t4_after", matrix_n, e);
    send(8'hF0); key(8'h5A);
    chk_vec("t4_after_brk", matrix_n, ALL1);

    // fake shifts around an extended key
    send(8'hE0); key(8'h12);
    chk_bit("t5_fake_make", shift_out, 1'b0);
    send(8'hE0); key(8'h75);
    e = ALL1; e[54] = 1'b0;
    chk_vec("t5_up", matrix_n, e);
    chk_bit("t5_up_shift", shift_out, 1'b0);
    send(8'hE0); send(8'hF0); key(8'h75);
    chk_vec("t5_up_brk", matrix_n, ALL1);
    send(8'hE0); send(8'hF0); key(8'h12);
    chk_bit("t5_fake_brk", shift_out, 1'b0);

    // forced shift and shared cell
    key(8'h1E);
    key(8'h52);
    e = ALL1; e[2] = 1'b0; e[10] = 1'b0;
    chk_vec("f_on_cells", matrix_n, e);
    chk_bit("f_on_shift", shift_out, 1'b1);
    send(8'hF0); key(8'h52);
    chk_bit("f_on_release", shift_out, 1'b0);
    key(8'h12);
    key(8'h52);
    send(8'hF0); key(8'h12);
    send(8'hF0); key(8'h1E);
    e = ALL1; e[2] = 1'b0;
    chk_vec("f_shared", matrix_n, e);
    chk_bit("f_shared_shift", shift_out, 1'b1);
    send(8'hF0); key(8'h52);
    chk_vec("f_shared_clr", matrix_n, ALL1);
    chk_bit("f_shared_shift0", shift_out, 1'b0);
    key(8'h12);
    key(8'h55);
    e = ALL1; e[9] = 1'b0;
    chk_vec("f_off_cell", matrix_n, e);
    chk_bit("f_off_shift", shift_out, 1'b0);
    send(8'hF0); key(8'h55);
    chk_bit("f_off_release", shift_out, 1'b1);
    send(8'hF0); key(8'h12);
    chk_bit("f_shift_up", shift_out, 1'b0);

    // pause sequence swallows exactly seven bytes
    send(8'hE1);
    send(8'h14); send(8'h77); send(8'hE1); send(8'hF0);
    send(8'h14); send(8'hF0); send(8'h1C);
    tick(3);
    chk_vec("p_swallow", matrix_n, ALL1);
    key(8'h29);
    e = ALL1; e[30] = 1'b0;
    chk_vec("p_idle", matrix_n, e);
    send(8'hF0); key(8'h29);

    // ctrl+alt+del
    key(8'h14);
    key(8'h11);
    chk_bit("cad_no_del", reset_req, 1'b0);
    send(8'hE0); send(8'h71);
    chk_bit("cad_req", reset_req, 1'b1);
    wait_ready();
    chk_vec("cad_matrix", matrix_n, ALL1);
    send(8'hE0); send(8'hF0); send(8'h71);
    chk_bit("cad_release", reset_req, 1'b0);
    wait_ready();
    send(8'hF0); key(8'h14);
    send(8'hF0); key(8'h11);
    chk_bit("cad_rus", rus, 1'b1);

    // reset in the middle of an extended sequence
    send(8'hE0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk_bit("mr_ready", code_ready, 1'b1);
    chk_vec("mr_matrix", matrix_n, ALL1);
    chk_bit("mr_rus", rus, 1'b0);
    key(8'h5A);
    e = ALL1; e[35] = 1'b0;
    chk_vec("mr_plain", matrix_n, e);
    send(8'hF0); key(8'h5A);
    chk_vec("mr_break", matrix_n, ALL1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
